// File: rtl/data_ram_arbiter.sv
// data_ram_arbiter: shares the single data_ram port between the CPU data port
// (master 0) and a secondary master (master 1). Each master gets one transfer
// at a time through a req/ack handshake; the grant is round-robin or fixed
// priority, and every transfer runs IDLE -> ACCESS (1+WAIT_CYCLES) -> RESP.
module data_ram_arbiter #(
    parameter int WAIT_CYCLES = 0,
    parameter int FIX_PRIO    = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [3:0]  m0_sel,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_ack,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [3:0]  m1_sel,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_ack,
    output logic        ram_ce,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [3:0]  ram_sel,
    output logic [31:0] ram_data_o,
    input  logic [31:0] ram_data_i,
    output logic        busy_o,
    output logic        owner_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t     state, state_next;
    logic       owner, owner_next;
    logic       last_owner, last_owner_next;
    logic [3:0] wait_cnt, wait_cnt_next;
    logic       grant;
    logic       owner_we;

    // Pick the winner among the current requesters; only used in IDLE.
    always_comb begin
        grant = 1'b0;
        if (m0_req && m1_req) begin
            grant = (FIX_PRIO != 0) ? 1'b0 : ~last_owner;
        end else if (m1_req) begin
            grant = 1'b1;
        end
    end

    assign owner_we = owner ? m1_we : m0_we;

    // State, owner and wait counter registers; last_owner starts at 1 so master 0 wins the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            wait_cnt   <= 4'd0;
        end else begin
            state      <= state_next;
            owner      <= owner_next;
            last_owner <= last_owner_next;
            wait_cnt   <= wait_cnt_next;
        end
    end

    // Next-state logic plus the RAM-side mux and the ack pulses.
    always_comb begin
        state_next      = state;
        owner_next      = owner;
        last_owner_next = last_owner;
        wait_cnt_next   = wait_cnt;
        ram_ce          = 1'b0;
        ram_we          = 1'b0;
        ram_addr        = 32'd0;
        ram_sel         = 4'd0;
        ram_data_o      = 32'd0;
        m0_ack          = 1'b0;
        m1_ack          = 1'b0;
        case (state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    owner_next      = grant;
                    last_owner_next = grant;
                    wait_cnt_next   = WAIT_INIT;
                    state_next      = ACCESS;
                end
            end
            ACCESS: begin
                ram_ce     = 1'b1;
                ram_we     = owner_we && (wait_cnt == 4'd0);
                ram_addr   = owner ? m1_addr  : m0_addr;
                ram_sel    = owner ? m1_sel   : m0_sel;
                ram_data_o = owner ? m1_wdata : m0_wdata;
                if (wait_cnt != 4'd0) begin
                    wait_cnt_next = wait_cnt - 4'd1;
                end else begin
                    state_next = RESP;
                end
            end
            RESP: begin
                m0_ack     = ~owner;
                m1_ack     = owner;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Read data is captured on the final ACCESS edge, only for the owner and only on reads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m0_rdata <= 32'd0;
            m1_rdata <= 32'd0;
        end else if (state == ACCESS && wait_cnt == 4'd0 && !owner_we) begin
            if (owner) begin
                m1_rdata <= ram_data_i;
            end else begin
                m0_rdata <= ram_data_i;
            end
        end
    end

    assign busy_o  = (state != IDLE);
    assign owner_o = owner;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Directed bench for data_ram_arbiter. Three instances share one clock:
// [0] WAIT_CYCLES=0 round-robin, [1] WAIT_CYCLES=3 round-robin,
// [2] WAIT_CYCLES=0 fixed priority. Each has its own data_ram model whose
// word i starts as 0x11223300+i, except word 4 (byte 0x10) = 0xDEADBEEF.
module tb_data_ram_arbiter;

    localparam int N = 3;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    logic [N-1:0] m0_req, m0_we, m1_req, m1_we;
    logic [N-1:0] m0_ack, m1_ack, ram_ce, ram_we, busy_o, owner_o;
    logic [31:0]  m0_addr [N];
    logic [31:0]  m0_wdata [N];
    logic [31:0]  m0_rdata [N];
    logic [31:0]  m1_addr [N];
    logic [31:0]  m1_wdata [N];
    logic [31:0]  m1_rdata [N];
    logic [31:0]  ram_addr [N];
    logic [31:0]  ram_data_o [N];
    logic [31:0]  ram_data_i [N];
    logic [3:0]   m0_sel [N];
    logic [3:0]   m1_sel [N];
    logic [3:0]   ram_sel [N];
    logic [7:0]   peek_idx;
    logic [31:0]  peek_val [N];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // One arbiter plus its data_ram model per configuration.
    for (genvar g = 0; g < N; g++) begin : gen_dut
        logic [31:0] mem [256];
        logic        init_done = 1'b0;

        data_ram_arbiter #(
            .WAIT_CYCLES((g == 1) ? 3 : 0),
            .FIX_PRIO   ((g == 2) ? 1 : 0)
        ) dut (
            .clk        (clk),
            .reset      (reset),
            .m0_req     (m0_req[g]),
            .m0_we      (m0_we[g]),
            .m0_addr    (m0_addr[g]),
            .m0_sel     (m0_sel[g]),
            .m0_wdata   (m0_wdata[g]),
            .m0_rdata   (m0_rdata[g]),
            .m0_ack     (m0_ack[g]),
            .m1_req     (m1_req[g]),
            .m1_we      (m1_we[g]),
            .m1_addr    (m1_addr[g]),
            .m1_sel     (m1_sel[g]),
            .m1_wdata   (m1_wdata[g]),
            .m1_rdata   (m1_rdata[g]),
            .m1_ack     (m1_ack[g]),
            .ram_ce     (ram_ce[g]),
            .ram_we     (ram_we[g]),
            .ram_addr   (ram_addr[g]),
            .ram_sel    (ram_sel[g]),
            .ram_data_o (ram_data_o[g]),
            .ram_data_i (ram_data_i[g]),
            .busy_o     (busy_o[g]),
            .owner_o    (owner_o[g])
        );

        assign ram_data_i[g] = mem[ram_addr[g][9:2]];
        assign peek_val[g]   = mem[peek_idx];

        // Memory model: preload on the first edge, then byte-masked writes.
        always @(posedge clk) begin
            if (!init_done) begin
                for (int i = 0; i < 256; i++) begin
                    mem[i] <= (i == 4) ? 32'hDEADBEEF : (32'h11223300 + 32'(i));
                end
                init_done <= 1'b1;
            end else if (ram_ce[g] && ram_we[g]) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_sel[g][b]) begin
                        mem[ram_addr[g][9:2]][b*8 +: 8] <= ram_data_o[g][b*8 +: 8];
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int g, input bit port, input bit req, input bit we,
                                 input logic [31:0] addr, input logic [3:0] sel,
                                 input logic [31:0] wdata);
        if (port) begin
            m1_req[g] = req; m1_we[g] = we; m1_addr[g] = addr; m1_sel[g] = sel; m1_wdata[g] = wdata;
        end else begin
            m0_req[g] = req; m0_we[g] = we; m0_addr[g] = addr; m0_sel[g] = sel; m0_wdata[g] = wdata;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic checkBit(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    initial begin
        for (int g = 0; g < N; g++) begin
            applyStimulus(g, 1'b0, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
            applyStimulus(g, 1'b1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
        end
        peek_idx = 8'd12;
        tick();
        tick();

        // Reset state
        checkBit("rst_ce", ram_ce[0], 1'b0);
        checkBit("rst_we", ram_we[0], 1'b0);
        checkBit("rst_busy", busy_o[0], 1'b0);
        checkBit("rst_owner", owner_o[0], 1'b0);
        checkBit("rst_owner_fix", owner_o[2], 1'b0);
        checkBit("rst_ack0", m0_ack[0], 1'b0);
        checkOutput("rst_rdata0", m0_rdata[0], 32'd0);
        checkOutput("rst_addr", ram_addr[0], 32'd0);
        reset = 1'b1;

        // m0 read of 0x10, no wait states
        applyStimulus(0, 1'b0, 1'b1, 1'b0, 32'h10, 4'hF, 32'd0);
        tick();
        checkBit("t1_ce_access", ram_ce[0], 1'b1);
        checkBit("t1_we_access", ram_we[0], 1'b0);
        checkOutput("t1_addr", ram_addr[0], 32'h10);
        checkBit("t1_busy", busy_o[0], 1'b1);
        checkBit("t1_ack_early", m0_ack[0], 1'b0);
        tick();
        checkBit("t1_ack", m0_ack[0], 1'b1);
        checkBit("t1_m1_ack", m1_ack[0], 1'b0);
        checkOutput("t1_rdata", m0_rdata[0], 32'hDEADBEEF);
        checkBit("t1_ce_resp", ram_ce[0], 1'b0);
        checkBit("t1_owner", owner_o[0], 1'b0);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h10, 4'hF, 32'd0);
        tick();
        checkBit("t1_ce_idle", ram_ce[0], 1'b0);
        checkBit("t1_busy_idle", busy_o[0], 1'b0);
        checkBit("t1_ack_idle", m0_ack[0], 1'b0);

        // m0 drops req during ACCESS
        applyStimulus(0, 1'b0, 1'b1, 1'b0, 32'h10, 4'hF, 32'd0);
        tick();
        checkBit("t6_busy_access", busy_o[0], 1'b1);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h10, 4'hF, 32'd0);
        tick();
        checkBit("t6_ack", m0_ack[0], 1'b1);
        tick();
        checkBit("t6_ack_once", m0_ack[0], 1'b0);
        checkBit("t6_busy_idle", busy_o[0], 1'b0);
        tick();
        checkBit("t6_still_idle", busy_o[0], 1'b0);
        checkBit("t6_ack_none", m0_ack[0], 1'b0);

        // Async reset in the middle of an m0 write to 0x30
        applyStimulus(0, 1'b0, 1'b1, 1'b1, 32'h30, 4'hF, 32'hCAFEF00D);
        tick();
        checkBit("t5_we_before", ram_we[0], 1'b1);
        checkBit("t5_ce_before", ram_ce[0], 1'b1);
        checkOutput("t5_wdata", ram_data_o[0], 32'hCAFEF00D);
        #3;
        reset = 1'b0;
        #1;
        checkBit("t5_we_async", ram_we[0], 1'b0);
        checkBit("t5_ce_async", ram_ce[0], 1'b0);
        checkBit("t5_busy_async", busy_o[0], 1'b0);
        tick();
        checkBit("t5_no_ack", m0_ack[0], 1'b0);
        checkOutput("t5_word_kept", peek_val[0], 32'h1122330C);
        reset = 1'b1;
        tick();
        checkBit("t5_reserve_we", ram_we[0], 1'b1);
        tick();
        checkBit("t5_reserve_ack", m0_ack[0], 1'b1);
        checkOutput("t5_word_written", peek_val[0], 32'hCAFEF00D);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h30, 4'hF, 32'd0);
        tick();
        checkBit("t5_ack_gone", m0_ack[0], 1'b0);

        // m1 byte-lane write with three wait states, then read back via m0
        applyStimulus(1, 1'b1, 1'b1, 1'b1, 32'h20, 4'b0010, 32'h0000AB00);
        for (int k = 1; k <= 4; k++) begin
            tick();
            checkBit($sformatf("t2_ce_%0d", k), ram_ce[1], 1'b1);
            checkBit($sformatf("t2_we_%0d", k), ram_we[1], (k == 4));
            checkBit($sformatf("t2_ack_%0d", k), m1_ack[1], 1'b0);
        end
        checkOutput("t2_sel", {28'd0, ram_sel[1]}, 32'h2);
        checkOutput("t2_wdata", ram_data_o[1], 32'h0000AB00);
        checkOutput("t2_addr", ram_addr[1], 32'h20);
        tick();
        checkBit("t2_ack", m1_ack[1], 1'b1);
        checkBit("t2_ce_resp", ram_ce[1], 1'b0);
        checkBit("t2_owner", owner_o[1], 1'b1);
        checkOutput("t2_rdata_kept", m1_rdata[1], 32'd0);
        applyStimulus(1, 1'b1, 1'b0, 1'b0, 32'h20, 4'b0010, 32'd0);
        tick();
        applyStimulus(1, 1'b0, 1'b1, 1'b0, 32'h20, 4'hF, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            tick();
        end
        tick();
        checkBit("t2_rb_ack", m0_ack[1], 1'b1);
        checkOutput("t2_rb_data", m0_rdata[1], 32'h1122AB08);
        checkBit("t2_rb_m1_ack", m1_ack[1], 1'b0);
        checkOutput("t2_rb_m1_rdata", m1_rdata[1], 32'd0);
        applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'h20, 4'hF, 32'd0);
        tick();

        // Fresh reset, then continuous contention on [0] (round-robin) and [2] (fixed priority)
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int g = 0; g < N; g += 2) begin
            applyStimulus(g, 1'b0, 1'b1, 1'b0, 32'h10, 4'hF, 32'd0);
            applyStimulus(g, 1'b1, 1'b1, 1'b0, 32'h20, 4'hF, 32'd0);
        end
        for (int k = 1; k <= 17; k++) begin
            tick();
            checkBit($sformatf("rr_m0_ack_%0d", k), m0_ack[0], (k % 3 == 2) && ((k / 3) % 2 == 0));
            checkBit($sformatf("rr_m1_ack_%0d", k), m1_ack[0], (k % 3 == 2) && ((k / 3) % 2 == 1));
            checkBit($sformatf("fp_m0_ack_%0d", k), m0_ack[2], (k % 3 == 2));
            checkBit($sformatf("fp_m1_ack_%0d", k), m1_ack[2], 1'b0);
        end
        checkOutput("rr_m0_rdata", m0_rdata[0], 32'hDEADBEEF);
        checkOutput("rr_m1_rdata", m1_rdata[0], 32'h11223308);
        applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h10, 4'hF, 32'd0);
        applyStimulus(0, 1'b1, 1'b0, 1'b0, 32'h20, 4'hF, 32'd0);
        applyStimulus(2, 1'b0, 1'b0, 1'b0, 32'h10, 4'hF, 32'd0);
        tick();
        checkBit("fp_idle_busy", busy_o[2], 1'b0);
        checkBit("fp_idle_m1_ack", m1_ack[2], 1'b0);
        checkBit("rr_idle_busy", busy_o[0], 1'b0);
        tick();
        checkBit("fp_m1_grant_owner", owner_o[2], 1'b1);
        checkBit("fp_m1_grant_busy", busy_o[2], 1'b1);
        checkBit("rr_stays_idle", busy_o[0], 1'b0);
        tick();
        checkBit("fp_m1_ack", m1_ack[2], 1'b1);
        checkOutput("fp_m1_rdata", m1_rdata[2], 32'h11223308);
        applyStimulus(2, 1'b1, 1'b0, 1'b0, 32'h20, 4'hF, 32'd0);
        tick();
        checkBit("fp_done", busy_o[2], 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_ram_arbiter.md
Name: data_ram_arbiter

Overview:
- Shares the single data_ram port between two masters.
- Master 0 is the CPU data port (ram_* of mips); master 1 is a secondary master (DMA / debug loader).
- Sits between the masters and data_ram inside the SOPC top.
- Single-outstanding req/ack handshake per master, round-robin or fixed-priority arbitration, programmable wait states, registered read data.

Parameters:
- WAIT_CYCLES, 0: extra ACCESS cycles per transfer (0..15).
- FIX_PRIO, 0: 0 = round-robin; 1 = master 0 always wins contention.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- m0_req  in  1  master 0 request, held until m0_ack
- m0_we  in  1  master 0 write enable (1 = write)
- m0_addr  in  32  master 0 byte address
- m0_sel  in  4  master 0 byte lane select
- m0_wdata  in  32  master 0 write data
- m0_rdata  out  32  master 0 read data, valid in the m0_ack cycle
- m0_ack  out  1  master 0 one-cycle completion pulse
- m1_req, m1_we, m1_addr, m1_sel, m1_wdata, m1_rdata, m1_ack: same as master 0, for master 1
- ram_ce  out  1  data_ram chip enable
- ram_we  out  1  data_ram write enable
- ram_addr  out  32  data_ram address
- ram_sel  out  4  data_ram byte select
- ram_data_o  out  32  write data to data_ram
- ram_data_i  in  32  read data from data_ram (combinational read when ce=1)
- busy_o  out  1  high in any state other than IDLE
- owner_o  out  1  current or last granted master

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, wait counter=0, last_owner=1, so master 0 wins the first tie.
  - All outputs 0, including m*_rdata and owner_o.
  - An in-flight write is aborted; ram_we drops immediately.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - ram_ce=ram_we=0; ram_addr, ram_sel, ram_data_o = 0.
  - If any req is high at a clk edge: latch the winner into owner, load wait counter=WAIT_CYCLES, go to ACCESS.
- Arbitration:
  - One requester: it wins.
  - Both requesting, FIX_PRIO=1: master 0 wins.
  - Both requesting, FIX_PRIO=0: the master that is not last_owner wins.
  - last_owner updates on every grant.
- ACCESS (lasts 1+WAIT_CYCLES cycles):
  - ram_ce=1; ram_addr, ram_sel, ram_data_o muxed combinationally from the owner's inputs.
  - ram_we = owner we AND (counter==0), so a write happens exactly once, at the final ACCESS edge.
  - If counter!=0: decrement.
  - If counter==0: capture ram_data_i into owner's m*_rdata (reads only; writes leave rdata unchanged) and go to RESP.
- RESP (1 cycle):
  - Owner's m*_ack=1; ram_ce=0; go to IDLE.
  - req inputs are ignored here; a master re-asserting req is served from IDLE on the next edge.
- Latency and throughput:
  - req seen at IDLE edge N → ack high in cycle N+2+WAIT_CYCLES.
  - Per-master throughput is 1 transfer per 3+WAIT_CYCLES cycles.
- A non-owner's ack is never asserted; its rdata holds its last value.
- Owner drops req mid-ACCESS: a protocol violation. The transfer still completes and ack is pulsed; requests are not cancelled.
- A master that is not granted simply keeps req high; no request is lost.
- No starvation: with FIX_PRIO=0, two continuously requesting masters strictly alternate.
- owner_o and busy_o are registered, derived from state/owner only.

Test Plan:
- Reset then m0 read: m0_addr=0x10, data_ram[0x10]=0xDEADBEEF, WAIT_CYCLES=0 → ram_ce high exactly 1 cycle; m0_ack in the 2nd cycle after the req edge; m0_rdata=0xDEADBEEF; m1_ack stays 0.
- m1 byte write: addr=0x20, sel=4'b0010, wdata=0x0000AB00, WAIT_CYCLES=3 → ram_ce high 4 cycles, ram_we high only the last; read-back via m0 shows byte 1 = 0xAB, other bytes unchanged; ack 5 cycles after req.
- Simultaneous continuous req from both, FIX_PRIO=0, 6 transfers → grant order 0,1,0,1,0,1; each ack spacing 3 cycles.
- Same stimulus, FIX_PRIO=1 → m0 wins all 6 contention cycles; m1 served only after m0_req drops.
- Assert reset=0 asynchronously mid-ACCESS of an m0 write → ram_we/ram_ce drop immediately, no ack, target word unchanged; after release, pending m0 req is re-served with the correct ack.
- m0 drops req in the ACCESS cycle (protocol violation) → transfer completes, m0_ack pulses once, state returns to IDLE, busy_o=0 the next cycle.
